seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, MCLK cycles per digit slot (1 kHz slot rate at 50 MHz); SHALL be > BLANK_CYCLES.
REQ-002 Parameter BLANK_CYCLES, default 1000, anti-ghost blanking cycles at the start of each slot; SHALL be >= 0.
REQ-003 MCLK  input  1  single clock; all state SHALL be on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 digits_in  input  16  four hex nibbles; [3:0] is digit 0, shown on an[0], which is the rightmost digit.
REQ-006 dp_in  input  4  decimal point request per digit, 1 = lit.
REQ-007 digit_en  input  4  per-digit enable, 0 = digit dark for its slot.
REQ-008 load  input  1  level-sampled request to capture digits_in, dp_in and digit_en.
REQ-009 load_ack  output  1  one-cycle pulse when captured data becomes active.
REQ-010 frame_start  output  1  one-cycle pulse at the start of every frame.
REQ-011 seg  output  7  active-low segments; seg[0]=a through seg[6]=g.
REQ-012 an  output  4  active-low anode selects.
REQ-013 dp  output  1  active-low decimal point.

Function
REQ-014 The block SHALL use two states, BLANK and DRIVE, with a slot counter and a 2-bit digit index d.
REQ-015 BLANK SHALL last BLANK_CYCLES cycles with an=4'hF, seg=7'h7F and dp=1, then move to DRIVE.
REQ-016 If BLANK_CYCLES=0, BLANK SHALL be skipped entirely.
REQ-017 DRIVE SHALL last SCAN_DIV-BLANK_CYCLES cycles.
REQ-018 In DRIVE, an[d] SHALL be 0 and the other anode bits 1 when active_en[d]=1; an SHALL be 4'hF when active_en[d]=0.
REQ-019 On leaving DRIVE, d SHALL increment and wrap from 3 to 0, so one frame = 4*SCAN_DIV cycles.
REQ-020 Frame boundary = the cycle d wraps 3->0. frame_start SHALL pulse on the first cycle of the new frame; there is no pulse on reset exit.
REQ-021 seg SHALL be the hex decode of the active nibble d, registered and aligned with an. Codes: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E; remaining codes follow the standard hex font.
REQ-022 dp SHALL be ~active_dp[d] in DRIVE with the digit enabled; otherwise dp=1.
REQ-023 Double buffer: load=1 in any cycle SHALL copy the inputs into the staging registers and set pending. A later load before the boundary SHALL overwrite staging (last wins).
REQ-024 At the frame boundary with pending=1, staging SHALL copy to active, pending SHALL clear, and load_ack SHALL pulse in the same cycle as frame_start.
REQ-025 A load coincident with the boundary cycle SHALL take effect at that boundary: its data goes straight to active, and load_ack pulses.
REQ-026 Active registers SHALL never change mid-frame.
REQ-027 The slot counter SHALL be $clog2(SCAN_DIV) bits wide and SHALL count 0..limit-1, then reset to 0.

Reset
REQ-028 While reset_n=0: state=BLANK, d=0, counter=0, active and staging registers = 0, pending=0.
REQ-029 While reset_n=0, outputs SHALL be an=4'hF, seg=7'h7F, dp=1, load_ack=0, frame_start=0.
REQ-030 Reset asserted mid-frame SHALL discard pending data and force outputs to their reset values immediately.
REQ-031 After release, scanning SHALL begin at BLANK, digit 0, with the display dark until the first load is applied.

Verification
REQ-032 Bench parameters SHALL be SCAN_DIV=8 and BLANK_CYCLES=2, giving a frame of 32 cycles.
REQ-033 Release reset, no load: an=4'hF and seg=7'h7F for 64 cycles; frame_start pulses at cycles 32 and 64; load_ack never pulses.
REQ-034 load digits_in=16'h8A10, dp_in=4'b0100, digit_en=4'hF mid-frame -> no change until the boundary; then load_ack and frame_start pulse together.
REQ-035 Same stimulus, next frame: per slot, 2 blank cycles then 6 drive cycles; an=1110 seg=7'h40, an=1101 seg=7'h79, an=1011 seg=7'h08 dp=0, an=0111 seg=7'h00.
REQ-036 digit_en=4'b0101 applied -> slots 1 and 3 show an=4'hF, seg=7'h7F, dp=1; frame timing unchanged.
REQ-037 Two loads in one frame (16'h1111 then 16'hFFFF) -> a single load_ack; all digits show 7'h0E.
REQ-038 Load 16'h1111 so the active digits show 7'h79, then load=1 exactly on the boundary cycle with 16'h2222 -> 16'h2222 becomes active at that boundary and load_ack pulses. With an active frame underway and a new load pending, drop reset_n for 1 cycle mid-frame -> outputs reach reset values asynchronously, pending is discarded, and no load_ack follows.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Load requests are staged and only become active on a frame boundary.
module seg7_scan_ctrl #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        MCLK,
   input  logic        reset_n,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  digit_en,
   input  logic        load,
   output logic        load_ack,
   output logic        frame_start,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST =
      (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   // With no blanking the controller lives permanently in DRIVE.
   localparam state_t RST_STATE = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       dig_q, dig_d;

   logic [15:0]      stg_dig_q, stg_dig_d;
   logic [3:0]       stg_dp_q, stg_dp_d;
   logic [3:0]       stg_en_q, stg_en_d;
   logic             pend_q, pend_d;

   logic [15:0]      act_dig_q, act_dig_d;
   logic [3:0]       act_dp_q, act_dp_d;
   logic [3:0]       act_en_q, act_en_d;

   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             load_ack_q, load_ack_d;
   logic             frame_start_q, frame_start_d;

   logic             slot_last;
   logic             wrap;
   logic [3:0]       nib;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Slot sequencing, double buffering and next-cycle output decode.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + CNT_W'(1);
      dig_d         = dig_q;
      stg_dig_d     = stg_dig_q;
      stg_dp_d      = stg_dp_q;
      stg_en_d      = stg_en_q;
      pend_d        = pend_q;
      act_dig_d     = act_dig_q;
      act_dp_d      = act_dp_q;
      act_en_d      = act_en_q;
      load_ack_d    = 1'b0;
      frame_start_d = 1'b0;
      an_d          = 4'hF;
      seg_d         = 7'h7F;
      dp_d          = 1'b1;
      nib           = 4'h0;

      slot_last = (state_q == S_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == DRIVE_LAST);
      wrap      = (state_q == S_DRIVE) && slot_last && (dig_q == 2'd3);

      if (slot_last) begin
         cnt_d = '0;
         if (state_q == S_BLANK) begin
            state_d = S_DRIVE;
         end else begin
            dig_d   = dig_q + 2'd1;
            state_d = RST_STATE;
         end
      end

      // A load on the boundary cycle bypasses staging and wins over pending data.
      if (wrap) begin
         frame_start_d = 1'b1;
         pend_d        = 1'b0;
         if (load) begin
            act_dig_d  = digits_in;
            act_dp_d   = dp_in;
            act_en_d   = digit_en;
            load_ack_d = 1'b1;
         end else if (pend_q) begin
            act_dig_d  = stg_dig_q;
            act_dp_d   = stg_dp_q;
            act_en_d   = stg_en_q;
            load_ack_d = 1'b1;
         end
      end else if (load) begin
         stg_dig_d = digits_in;
         stg_dp_d  = dp_in;
         stg_en_d  = digit_en;
         pend_d    = 1'b1;
      end

      nib = act_dig_d[{dig_d, 2'b00} +: 4];
      if ((state_d == S_DRIVE) && act_en_d[dig_d]) begin
         an_d[dig_d] = 1'b0;
         seg_d       = hex7(nib);
         dp_d        = ~act_dp_d[dig_d];
      end
   end

   always_ff @(posedge MCLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RST_STATE;
         cnt_q         <= '0;
         dig_q         <= 2'd0;
         stg_dig_q     <= 16'h0000;
         stg_dp_q      <= 4'h0;
         stg_en_q      <= 4'h0;
         pend_q        <= 1'b0;
         act_dig_q     <= 16'h0000;
         act_dp_q      <= 4'h0;
         act_en_q      <= 4'h0;
         an_q          <= 4'hF;
         seg_q         <= 7'h7F;
         dp_q          <= 1'b1;
         load_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dig_q         <= dig_d;
         stg_dig_q     <= stg_dig_d;
         stg_dp_q      <= stg_dp_d;
         stg_en_q      <= stg_en_d;
         pend_q        <= pend_d;
         act_dig_q     <= act_dig_d;
         act_dp_q      <= act_dp_d;
         act_en_q      <= act_en_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         load_ack_q    <= load_ack_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign load_ack    = load_ack_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-position reference model
// predicts every output cycle; a monitor compares on the falling edge.
module tb_seg7_scan_ctrl;

   localparam int FRAME = 32;
   localparam int SLOT  = 8;
   localparam int BLANK = 2;
   localparam logic [13:0] RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

   logic        MCLK = 1'b0;
   logic        reset_n;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        load;
   logic        load_ack;
   logic        frame_start;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [13:0] exp_q[$];
   logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
      .MCLK        (MCLK),
      .reset_n     (reset_n),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .load        (load),
      .load_ack    (load_ack),
      .frame_start (frame_start),
      .seg         (seg),
      .an          (an),
      .dp          (dp)
   );

   always #5 MCLK = ~MCLK;

   // Reference model: display contents are a function of position within the frame.
   initial begin : model
      int          k;
      int          t;
      int          slot;
      int          pos;
      bit          pend;
      bit          ack;
      logic [15:0] a_dig, s_dig, sh;
      logic [3:0]  a_dp, s_dp, a_en, s_en;
      logic [3:0]  an_e;
      logic [6:0]  seg_e;
      logic        dp_e;
      k = 0; pend = 0;
      a_dig = '0; a_dp = '0; a_en = '0;
      s_dig = '0; s_dp = '0; s_en = '0;
      forever begin
         @(posedge MCLK);
         if (!reset_n) begin
            k = 0; pend = 0;
            a_dig = '0; a_dp = '0; a_en = '0;
            s_dig = '0; s_dp = '0; s_en = '0;
            exp_q.push_back(RST_OUT);
         end else begin
            ack = 0;
            if ((k + 1) % FRAME == 0) begin
               if (load) begin
                  a_dig = digits_in; a_dp = dp_in; a_en = digit_en; ack = 1;
               end else if (pend) begin
                  a_dig = s_dig; a_dp = s_dp; a_en = s_en; ack = 1;
               end
               pend = 0;
            end else if (load) begin
               s_dig = digits_in; s_dp = dp_in; s_en = digit_en; pend = 1;
            end
            k++;
            t    = k % FRAME;
            slot = t / SLOT;
            pos  = t % SLOT;
            an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
            if (pos >= BLANK && a_en[slot]) begin
               an_e[slot] = 1'b0;
               sh    = a_dig >> (4 * slot);
               seg_e = font[sh[3:0]];
               dp_e  = ~a_dp[slot];
            end
            exp_q.push_back({an_e, seg_e, dp_e, ack, (t == 0)});
         end
      end
   end

   // Monitor: one expected output word per clock.
   initial begin : monitor
      logic [13:0] e;
      logic [13:0] g;
      forever begin
         @(negedge MCLK);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {an, seg, dp, load_ack, frame_start};
            total++;
            if (g !== e) begin
               bad++;
               $display("FAIL cycle_out t=%0t got an=%b seg=%h dp=%b ack=%b fs=%b need an=%b seg=%h dp=%b ack=%b fs=%b",
                        $time, g[13:10], g[9:3], g[2], g[1], g[0],
                        e[13:10], e[9:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge MCLK);
         #1;
         cyc++;
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic do_load(input logic [15:0] dv, input logic [3:0] pv, input logic [3:0] ev);
      digits_in = dv;
      dp_in     = pv;
      digit_en  = ev;
      load      = 1'b1;
      tick(1);
      load      = 1'b0;
      digits_in = 16'($urandom);
      dp_in     = 4'($urandom);
      digit_en  = 4'($urandom);
   endtask

   task automatic reset_pulse();
      logic [13:0] g;
      @(negedge MCLK);
      #2;
      reset_n = 1'b0;
      #1;
      g = {an, seg, dp, load_ack, frame_start};
      total++;
      if (g !== RST_OUT) begin
         bad++;
         $display("FAIL async_reset got=%h need=%h", g, RST_OUT);
      end
      @(negedge MCLK);
      #2;
      reset_n = 1'b1;
      cyc     = 0;
   endtask

   initial begin : stim
      reset_n   = 1'b0;
      load      = 1'b0;
      digits_in = 16'h0000;
      dp_in     = 4'h0;
      digit_en  = 4'h0;
      repeat (3) @(posedge MCLK);
      @(negedge MCLK);
      #2;
      reset_n = 1'b1;
      cyc     = 0;

      run_to(70);
      do_load(16'h8A10, 4'b0100, 4'hF);
      run_to(130);
      do_load(16'h8A10, 4'b0100, 4'b0101);
      run_to(195);
      do_load(16'h1111, 4'h0, 4'hF);
      run_to(200);
      do_load(16'hFFFF, 4'h0, 4'hF);
      run_to(260);
      do_load(16'h1111, 4'h0, 4'hF);
      run_to(FRAME * 10 - 1);
      do_load(16'h2222, 4'h0, 4'hF);
      run_to(330);
      do_load(16'h3333, 4'hF, 4'hF);
      run_to(340);
      reset_pulse();
      run_to(80);

      for (int i = 0; i < 400; i++) begin
         if ((cyc % FRAME == FRAME - 1) ? ($urandom_range(0, 1) == 0)
                                        : ($urandom_range(0, 11) == 0))
            do_load(16'($urandom), 4'($urandom), 4'($urandom));
         else
            tick(1);
      end
      tick(3);
      @(negedge MCLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
